// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control sequencer.
// Optional build macro: MC_CTRL_EXCEPTION_EN (illegal-opcode exception state).
package mc_ctrl_pkg;

  localparam int WIDTH    = 32;
  localparam int OPCODE_W = 6;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_RTYPE   = 6'h00;
  localparam opcode_t OP_J       = 6'h02;
  localparam opcode_t OP_JAL     = 6'h03;
  localparam opcode_t OP_BEQ     = 6'h04;
  localparam opcode_t OP_BNE     = 6'h05;
  localparam opcode_t OP_IALU_LO = 6'h08;
  localparam opcode_t OP_ISGN_HI = 6'h0B;
  localparam opcode_t OP_IALU_HI = 6'h0E;
  localparam opcode_t OP_LW      = 6'h23;
  localparam opcode_t OP_SW      = 6'h2B;
  localparam opcode_t OP_HALT    = 6'h3F;

  localparam logic [5:0] ALU_ADD   = 6'h20;
  localparam logic [5:0] ALU_FUNCT = 6'h00;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_R_EXEC,
    S_R_WB,
    S_I_EXEC,
    S_I_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT,
    S_EXC
  } state_t;

  function automatic logic is_ialu(opcode_t op);
    return (op >= OP_IALU_LO) && (op <= OP_IALU_HI);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Memory request/ready handshake between the sequencer and memory.
// master = sequencer side, slave = memory side.
interface mc_ctrl_if;
  logic mem_req;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Bounded wait counter with sticky timeout flag.
// expire fires combinationally on the LIMIT-th consecutive wait cycle.
module mc_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic wait_cyc,
  output logic expire,
  output logic timeout
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expire = wait_cyc && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (wait_cyc)
        cnt <= cnt + CW'(1);
      if (expire)
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control sequencer with memory wait timeout and HALT.
// Optional build macro: MC_CTRL_EXCEPTION_EN adds EXC state and illegal_op.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  opcode_t    ir_31_26,
  mc_ctrl_if.master  mem,
  output logic       pc_write_cond,
  output logic       pc_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       jump_and_link,
  output logic       is_signed,
  output logic [1:0] pc_source,
  output logic [5:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       halted,
`ifdef MC_CTRL_EXCEPTION_EN
  output logic       illegal_op,
`endif
  output logic       mem_timeout
);

  state_t state, next;
  state_t dec_next;
  logic   req, wr, iord;
  logic   ready;
  logic   expire;
  opcode_t op;

  assign op    = ir_31_26;
  assign ready = mem.mem_ready;

  assign mem.mem_req   = req;
  assign mem.mem_write = wr;
  assign mem.i_or_d    = iord;

  mc_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (next != state),
    .wait_cyc (req && !ready),
    .expire   (expire),
    .timeout  (mem_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_INIT;
    else
      state <= next;
  end

  always_comb begin
    dec_next = S_FETCH;
    unique case (1'b1)
      (op == OP_RTYPE):             dec_next = S_R_EXEC;
      (op == OP_LW || op == OP_SW): dec_next = S_MEM_ADDR;
      (op == OP_BEQ || op == OP_BNE): dec_next = S_BRANCH;
      (op == OP_J || op == OP_JAL): dec_next = S_JUMP;
      is_ialu(op):                  dec_next = S_I_EXEC;
      (op == OP_HALT):              dec_next = S_HALT;
`ifdef MC_CTRL_EXCEPTION_EN
      default:                      dec_next = S_EXC;
`else
      default:                      dec_next = S_FETCH;
`endif
    endcase
  end

  always_comb begin
    next = state;
    unique case (state)
      S_INIT:     next = S_FETCH;
      S_FETCH:
        if (expire)     next = S_HALT;
        else if (ready) next = S_DECODE;
      S_DECODE:   next = dec_next;
      S_R_EXEC:   next = S_R_WB;
      S_R_WB:     next = S_FETCH;
      S_I_EXEC:   next = S_I_WB;
      S_I_WB:     next = S_FETCH;
      S_MEM_ADDR: next = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        if (expire)     next = S_HALT;
        else if (ready) next = S_MEM_WB;
      S_MEM_WB:   next = S_FETCH;
      S_MEM_WR:
        if (expire)     next = S_HALT;
        else if (ready) next = S_FETCH;
      S_BRANCH:   next = S_FETCH;
      S_JUMP:     next = S_FETCH;
      S_HALT:     next = S_HALT;
      S_EXC:      next = S_FETCH;
      default:    next = S_INIT;
    endcase
  end

  always_comb begin
    req           = 1'b0;
    wr            = 1'b0;
    iord          = 1'b0;
    pc_write_cond = 1'b0;
    pc_write      = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    jump_and_link = 1'b0;
    is_signed     = 1'b0;
    pc_source     = PCS_ALU;
    alu_op        = '0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    halted        = 1'b0;
`ifdef MC_CTRL_EXCEPTION_EN
    illegal_op    = 1'b0;
`endif
    unique case (state)
      S_FETCH: begin
        req = 1'b1;
        if (ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        alu_op    = ALU_ADD;
        is_signed = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = op;
        is_signed = (op <= OP_ISGN_HI);
      end
      S_I_WB:     reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        is_signed = 1'b1;
        alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        req  = 1'b1;
        iord = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        req  = 1'b1;
        wr   = 1'b1;
        iord = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = op;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        pc_write      = 1'b1;
        pc_source     = PCS_JUMP;
        jump_and_link = (op == OP_JAL);
      end
      S_HALT:     halted = 1'b1;
      S_EXC: begin
        pc_write   = 1'b1;
        pc_source  = PCS_EXC;
`ifdef MC_CTRL_EXCEPTION_EN
        illegal_op = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed per-cycle vector bench for mc_ctrl_fsm.
// Expected outputs are hand-built per state from the control table.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       pc_write_cond;
    logic       pc_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       jump_and_link;
    logic       is_signed;
    logic [1:0] pc_source;
    logic [5:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       halted;
    logic       illegal_op;
    logic       mem_timeout;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    outs_t      exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] ir;
  logic       pc_write_cond, pc_write, mem_to_reg, ir_write;
  logic       jump_and_link, is_signed, alu_src_a;
  logic       reg_write, reg_dst, halted, mem_timeout;
  logic       illegal_op;
  logic [1:0] pc_source, alu_src_b;
  logic [5:0] alu_op;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  mc_ctrl_if bus ();

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ir_31_26      (ir),
    .mem           (bus),
    .pc_write_cond (pc_write_cond),
    .pc_write      (pc_write),
    .mem_to_reg    (mem_to_reg),
    .ir_write      (ir_write),
    .jump_and_link (jump_and_link),
    .is_signed     (is_signed),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .halted        (halted),
`ifdef MC_CTRL_EXCEPTION_EN
    .illegal_op    (illegal_op),
`endif
    .mem_timeout   (mem_timeout)
  );

`ifndef MC_CTRL_EXCEPTION_EN
  assign illegal_op = 1'b0;
`endif

  function automatic outs_t cur();
    outs_t o;
    o.mem_req       = bus.mem_req;
    o.mem_write     = bus.mem_write;
    o.i_or_d        = bus.i_or_d;
    o.pc_write_cond = pc_write_cond;
    o.pc_write      = pc_write;
    o.mem_to_reg    = mem_to_reg;
    o.ir_write      = ir_write;
    o.jump_and_link = jump_and_link;
    o.is_signed     = is_signed;
    o.pc_source     = pc_source;
    o.alu_op        = alu_op;
    o.alu_src_a     = alu_src_a;
    o.alu_src_b     = alu_src_b;
    o.reg_write     = reg_write;
    o.reg_dst       = reg_dst;
    o.halted        = halted;
    o.illegal_op    = illegal_op;
    o.mem_timeout   = mem_timeout;
    return o;
  endfunction

  function automatic outs_t o_zero();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t o_fetch(logic r);
    outs_t o = '0;
    o.mem_req = 1'b1;
    if (r) begin
      o.ir_write  = 1'b1;
      o.pc_write  = 1'b1;
      o.alu_src_b = 2'b01;
      o.alu_op    = ALU_ADD;
    end
    return o;
  endfunction

  function automatic outs_t o_dec();
    outs_t o = '0;
    o.alu_src_b = 2'b11;
    o.alu_op    = ALU_ADD;
    o.is_signed = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_rexec();
    outs_t o = '0;
    o.alu_src_a = 1'b1;
    o.alu_op    = ALU_FUNCT;
    return o;
  endfunction

  function automatic outs_t o_wb(logic rd, logic m2r);
    outs_t o = '0;
    o.reg_write  = 1'b1;
    o.reg_dst    = rd;
    o.mem_to_reg = m2r;
    return o;
  endfunction

  function automatic outs_t o_iexec(logic [5:0] op, logic sgn);
    outs_t o = '0;
    o.alu_src_a = 1'b1;
    o.alu_src_b = 2'b10;
    o.alu_op    = op;
    o.is_signed = sgn;
    return o;
  endfunction

  function automatic outs_t o_maddr();
    outs_t o = '0;
    o.alu_src_a = 1'b1;
    o.alu_src_b = 2'b10;
    o.is_signed = 1'b1;
    o.alu_op    = ALU_ADD;
    return o;
  endfunction

  function automatic outs_t o_mem(logic w);
    outs_t o = '0;
    o.mem_req   = 1'b1;
    o.i_or_d    = 1'b1;
    o.mem_write = w;
    return o;
  endfunction

  function automatic outs_t o_branch(logic [5:0] op);
    outs_t o = '0;
    o.alu_src_a     = 1'b1;
    o.alu_op        = op;
    o.pc_write_cond = 1'b1;
    o.pc_source     = 2'b01;
    return o;
  endfunction

  function automatic outs_t o_jump(logic jal);
    outs_t o = '0;
    o.pc_write      = 1'b1;
    o.pc_source     = 2'b10;
    o.jump_and_link = jal;
    return o;
  endfunction

  function automatic outs_t o_halt(logic to);
    outs_t o = '0;
    o.halted      = 1'b1;
    o.mem_timeout = to;
    return o;
  endfunction

  function automatic outs_t o_exc();
    outs_t o = '0;
    o.pc_write   = 1'b1;
    o.pc_source  = 2'b11;
    o.illegal_op = 1'b1;
    return o;
  endfunction

  task automatic add(input logic [5:0] op, input logic rdy,
                     input outs_t exp, input string name);
    vec_t v;
    v.op   = op;
    v.rdy  = rdy;
    v.exp  = exp;
    v.name = name;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input outs_t exp);
    outs_t act;
    act = cur();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic rdy,
                      input outs_t exp, input string name);
    ir            = op;
    bus.mem_ready = rdy;
    @(negedge clk);
    chk(name, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    ir            = 6'h00;
    bus.mem_ready = 1'b1;

    add(6'h00, 1'b1, o_zero(),           "init");
    add(6'h00, 1'b1, o_fetch(1'b1),      "add_fetch");
    add(6'h00, 1'b1, o_dec(),            "add_decode");
    add(6'h00, 1'b1, o_rexec(),          "add_rexec");
    add(6'h00, 1'b1, o_wb(1'b1, 1'b0),   "add_rwb");
    add(6'h23, 1'b1, o_fetch(1'b1),      "lw_fetch");
    add(6'h23, 1'b1, o_dec(),            "lw_decode");
    add(6'h23, 1'b1, o_maddr(),          "lw_maddr");
    for (int i = 0; i < 3; i++)
      add(6'h23, 1'b0, o_mem(1'b0),      "lw_rd_wait");
    add(6'h23, 1'b1, o_mem(1'b0),        "lw_rd_done");
    add(6'h23, 1'b1, o_wb(1'b0, 1'b1),   "lw_memwb");
    add(6'h23, 1'b1, o_fetch(1'b1),      "lw15_fetch");
    add(6'h23, 1'b1, o_dec(),            "lw15_decode");
    add(6'h23, 1'b1, o_maddr(),          "lw15_maddr");
    for (int i = 0; i < 15; i++)
      add(6'h23, 1'b0, o_mem(1'b0),      "lw15_wait");
    add(6'h23, 1'b1, o_mem(1'b0),        "lw16_edge_ready");
    add(6'h23, 1'b1, o_wb(1'b0, 1'b1),   "lw16_memwb");
    add(6'h2B, 1'b1, o_fetch(1'b1),      "sw_fetch");
    add(6'h2B, 1'b1, o_dec(),            "sw_decode");
    add(6'h2B, 1'b1, o_maddr(),          "sw_maddr");
    add(6'h2B, 1'b1, o_mem(1'b1),        "sw_wr");
    add(6'h03, 1'b1, o_fetch(1'b1),      "jal_fetch");
    add(6'h03, 1'b1, o_dec(),            "jal_decode");
    add(6'h03, 1'b1, o_jump(1'b1),       "jal_jump");
    add(6'h02, 1'b1, o_fetch(1'b1),      "j_fetch");
    add(6'h02, 1'b1, o_dec(),            "j_decode");
    add(6'h02, 1'b1, o_jump(1'b0),       "j_jump");
    add(6'h05, 1'b1, o_fetch(1'b1),      "bne_fetch");
    add(6'h05, 1'b1, o_dec(),            "bne_decode");
    add(6'h05, 1'b1, o_branch(6'h05),    "bne_branch");
    add(6'h08, 1'b1, o_fetch(1'b1),      "addi_fetch");
    add(6'h08, 1'b1, o_dec(),            "addi_decode");
    add(6'h08, 1'b1, o_iexec(6'h08, 1'b1), "addi_iexec");
    add(6'h08, 1'b1, o_wb(1'b0, 1'b0),   "addi_iwb");
    add(6'h0D, 1'b1, o_fetch(1'b1),      "ori_fetch");
    add(6'h0D, 1'b1, o_dec(),            "ori_decode");
    add(6'h0D, 1'b1, o_iexec(6'h0D, 1'b0), "ori_iexec");
    add(6'h0D, 1'b1, o_wb(1'b0, 1'b0),   "ori_iwb");
    add(6'h3E, 1'b1, o_fetch(1'b1),      "ill_fetch");
    add(6'h3E, 1'b1, o_dec(),            "ill_decode");
`ifdef MC_CTRL_EXCEPTION_EN
    add(6'h3E, 1'b1, o_exc(),            "ill_exc");
`endif
    add(6'h3E, 1'b0, o_fetch(1'b0),      "fetch_wait1");
    add(6'h3E, 1'b0, o_fetch(1'b0),      "fetch_wait2");
    add(6'h2B, 1'b1, o_fetch(1'b1),      "swto_fetch");
    add(6'h2B, 1'b1, o_dec(),            "swto_decode");
    add(6'h2B, 1'b1, o_maddr(),          "swto_maddr");

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", o_zero());
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i])
      step(vecs[i].op, vecs[i].rdy, vecs[i].exp, vecs[i].name);

    // SW never acknowledged: 16 wait cycles, then HALT with timeout
    for (int i = 0; i < 16; i++)
      step(6'h2B, 1'b0, o_mem(1'b1), "swto_wait");
    step(6'h2B, 1'b0, o_halt(1'b1), "swto_halt");
    step(6'h2B, 1'b1, o_halt(1'b1), "swto_halt_hold");

    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_clears_timeout", o_zero());
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(6'h00, 1'b1, o_zero(),      "init2");
    step(6'h00, 1'b0, o_fetch(1'b0), "mid_fetch_wait");
    bus.mem_ready = 1'b0;
    #1 chk("mid_fetch_req", o_fetch(1'b0));
    #1 rst_n = 1'b0;
    #1 chk("mid_reset_drop", o_zero());
    @(posedge clk);
    #1 rst_n = 1'b1;

    step(6'h3F, 1'b1, o_zero(),      "init3");
    step(6'h3F, 1'b1, o_fetch(1'b1), "halt_fetch");
    step(6'h3F, 1'b1, o_dec(),       "halt_decode");
    step(6'h3F, 1'b1, o_halt(1'b0),  "halt_op");
    step(6'h00, 1'b1, o_halt(1'b0),  "halt_stay");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
